// File: rtl/studio2_keypad_port_if.sv
`default_nettype none
// ============================================================================
// Module   : studio2_keypad_port_if
// Brief    : CPU-side bus of the Studio II keypad port. The bus carries the
//            OUT strobe, the N lines and the data byte toward the port, and
//            the EF flags, latched key and any-key status back to the CPU.
// Revision : 1.0 - initial release
// ============================================================================
interface studio2_keypad_port_if;
  logic       io_out;
  logic [2:0] io_n;
  logic [7:0] io_dout;
  logic       ef3;
  logic       ef4;
  logic [3:0] key_latch;
  logic       any_key;

  // CPU / bench side
  modport master (
    output io_out, io_n, io_dout,
    input  ef3, ef4, key_latch, any_key
  );

  // keypad port side
  modport slave (
    input  io_out, io_n, io_dout,
    output ef3, ef4, key_latch, any_key
  );
endinterface
`default_nettype wire

// File: rtl/studio2_keypad_port.sv
`default_nettype none
// ============================================================================
// Module   : studio2_keypad_port
// Brief    : CPU-facing Studio II keypad responder. OUT 2 latches a key
//            number, and EF3/EF4 report whether that key is pressed on
//            keypad 1/2. PS/2 make events are stretched by HOLD_CYCLES so
//            that short taps are still seen by the polling loop.
// Config   : define STUDIO2_KEYPAD2_EN to build keypad 2 (numpad) and ef4.
//            When the macro is undefined, ef4 reads 0 and any_key covers
//            keypad 1 only.
// Revision : 1.0 - initial release
// ============================================================================
module studio2_keypad_port #(
  parameter int               CNT_W       = 20,
  parameter logic [CNT_W-1:0] HOLD_CYCLES = 20'd65535
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [10:0] ps2_key,
  studio2_keypad_port_if.slave bus
);

  logic       r_tog;
  logic [3:0] r_key_latch;
  logic       r_ef3;
  logic       r_any;
  logic       w_evt;
  logic [9:0] w_hit1;
  logic [9:0] w_make1;
  logic [9:0] w_brk1;
  logic [9:0] w_eff1;
  logic       w_any2;

  // Upper data nibble carries no meaning for the key select.
  wire w_unused_dout = ^bus.io_dout[7:4];

  // Toggle tracker follows ps2_key[10] every cycle, reset included, so
  // leaving reset never looks like a fresh event.
  always_ff @(posedge clk) begin
    r_tog <= ps2_key[10];
  end

  // A decodable event is a toggle on a non-extended code.
  assign w_evt = (ps2_key[10] != r_tog) && !ps2_key[8];

  // Keypad 1 scancode to one-hot digit (index = digit).
  always_comb begin
    w_hit1 = '0;
    case (ps2_key[7:0])
      8'h45:   w_hit1[0] = 1'b1;
      8'h16:   w_hit1[1] = 1'b1;
      8'h1E:   w_hit1[2] = 1'b1;
      8'h26:   w_hit1[3] = 1'b1;
      8'h25:   w_hit1[4] = 1'b1;
      8'h2E:   w_hit1[5] = 1'b1;
      8'h36:   w_hit1[6] = 1'b1;
      8'h3D:   w_hit1[7] = 1'b1;
      8'h3E:   w_hit1[8] = 1'b1;
      8'h46:   w_hit1[9] = 1'b1;
      default: w_hit1 = '0;
    endcase
  end

  assign w_make1 = w_hit1 & {10{w_evt &  ps2_key[9]}};
  assign w_brk1  = w_hit1 & {10{w_evt & ~ps2_key[9]}};

  for (genvar i = 0; i < 10; i++) begin : g_kp1
    logic             r_phys;
    logic [CNT_W-1:0] r_cnt;
    // Held flag plus stretch counter: make reloads, otherwise count down to 0.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_phys <= 1'b0;
        r_cnt  <= '0;
      end else if (w_make1[i]) begin
        r_phys <= 1'b1;
        r_cnt  <= HOLD_CYCLES;
      end else begin
        if (w_brk1[i]) r_phys <= 1'b0;
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end
    end
    assign w_eff1[i] = r_phys | (r_cnt != '0);
  end

`ifdef STUDIO2_KEYPAD2_EN
  logic [9:0] w_hit2;
  logic [9:0] w_make2;
  logic [9:0] w_brk2;
  logic [9:0] w_eff2;
  logic       r_ef4;

  // Keypad 2 (numpad) scancode to one-hot digit.
  always_comb begin
    w_hit2 = '0;
    case (ps2_key[7:0])
      8'h70:   w_hit2[0] = 1'b1;
      8'h69:   w_hit2[1] = 1'b1;
      8'h72:   w_hit2[2] = 1'b1;
      8'h7A:   w_hit2[3] = 1'b1;
      8'h6B:   w_hit2[4] = 1'b1;
      8'h73:   w_hit2[5] = 1'b1;
      8'h74:   w_hit2[6] = 1'b1;
      8'h6C:   w_hit2[7] = 1'b1;
      8'h75:   w_hit2[8] = 1'b1;
      8'h7D:   w_hit2[9] = 1'b1;
      default: w_hit2 = '0;
    endcase
  end

  assign w_make2 = w_hit2 & {10{w_evt &  ps2_key[9]}};
  assign w_brk2  = w_hit2 & {10{w_evt & ~ps2_key[9]}};

  for (genvar j = 0; j < 10; j++) begin : g_kp2
    logic             r_phys;
    logic [CNT_W-1:0] r_cnt;
    // Same held/stretch behaviour as keypad 1.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_phys <= 1'b0;
        r_cnt  <= '0;
      end else if (w_make2[j]) begin
        r_phys <= 1'b1;
        r_cnt  <= HOLD_CYCLES;
      end else begin
        if (w_brk2[j]) r_phys <= 1'b0;
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end
    end
    assign w_eff2[j] = r_phys | (r_cnt != '0);
  end

  assign w_any2 = |w_eff2;

  // EF4 reports the latched key on keypad 2; the zero pad covers 10..15.
  always_ff @(posedge clk) begin
    if (reset) r_ef4 <= 1'b0;
    else       r_ef4 <= ({6'b0, w_eff2} >> r_key_latch) != 16'd0 ? (({6'b0, w_eff2} >> r_key_latch) & 16'd1) != 16'd0 : 1'b0;
  end
  assign bus.ef4 = r_ef4;
`else
  assign w_any2  = 1'b0;
  assign bus.ef4 = 1'b0;
`endif

  // OUT 2 latches the key number from the low data nibble.
  always_ff @(posedge clk) begin
    if (reset)                             r_key_latch <= 4'h0;
    else if (bus.io_out && bus.io_n == 3'd2) r_key_latch <= bus.io_dout[3:0];
  end

  // EF3 and any-key are registered views of the current effective states.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ef3 <= 1'b0;
      r_any <= 1'b0;
    end else begin
      r_ef3 <= (({6'b0, w_eff1} >> r_key_latch) & 16'd1) != 16'd0;
      r_any <= (|w_eff1) | w_any2;
    end
  end

  assign bus.ef3       = r_ef3;
  assign bus.key_latch = r_key_latch;
  assign bus.any_key   = r_any;

endmodule
`default_nettype wire

// File: tb/tb_studio2_keypad_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_studio2_keypad_port
// Brief    : Self-checking bench for studio2_keypad_port with HOLD_CYCLES=8.
//            Directed scenarios plus a randomized run compared against a
//            behavioural model based on "edges since last make".
// Revision : 1.0 - initial release
// ============================================================================
module tb_studio2_keypad_port;
  localparam int HOLD = 8;
`ifdef STUDIO2_KEYPAD2_EN
  localparam bit KP2 = 1'b1;
`else
  localparam bit KP2 = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [10:0] ps2_key;
  int          checks;
  int          failures;

  studio2_keypad_port_if bus();

  studio2_keypad_port #(.CNT_W(20), .HOLD_CYCLES(20'd8)) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] c_kp1 [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] c_kp2 [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  bit   held1 [10];
  bit   made1 [10];
  int   age1  [10];
  bit   held2 [10];
  bit   made2 [10];
  int   age2  [10];
  logic [3:0] m_latch;
  bit   m_tog;
  bit   exp_ef3, exp_ef4, exp_any;

  function automatic bit eff1(int k);
    return held1[k] || (made1[k] && age1[k] < HOLD);
  endfunction

  function automatic bit eff2(int k);
    return held2[k] || (made2[k] && age2[k] < HOLD);
  endfunction

  function automatic int find1(logic [7:0] code);
    for (int k = 0; k < 10; k++) if (c_kp1[k] == code) return k;
    return -1;
  endfunction

  function automatic int find2(logic [7:0] code);
    for (int k = 0; k < 10; k++) if (c_kp2[k] == code) return k;
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs present there.
  function automatic void model_edge();
    int d1, d2;
    bit evt;
    if (reset) begin
      for (int k = 0; k < 10; k++) begin
        held1[k] = 0; made1[k] = 0; age1[k] = 0;
        held2[k] = 0; made2[k] = 0; age2[k] = 0;
      end
      m_latch = 4'h0;
      exp_ef3 = 0; exp_ef4 = 0; exp_any = 0;
      m_tog   = ps2_key[10];
      return;
    end
    exp_ef3 = (m_latch <= 9) ? eff1(int'(m_latch)) : 1'b0;
    exp_ef4 = (KP2 && m_latch <= 9) ? eff2(int'(m_latch)) : 1'b0;
    exp_any = 0;
    for (int k = 0; k < 10; k++) exp_any = exp_any | eff1(k) | (KP2 & eff2(k));
    evt   = (ps2_key[10] != m_tog);
    m_tog = ps2_key[10];
    for (int k = 0; k < 10; k++) begin
      if (made1[k] && age1[k] < HOLD) age1[k]++;
      if (made2[k] && age2[k] < HOLD) age2[k]++;
    end
    if (evt && !ps2_key[8]) begin
      d1 = find1(ps2_key[7:0]);
      d2 = find2(ps2_key[7:0]);
      if (d1 >= 0) begin
        if (ps2_key[9]) begin held1[d1] = 1; made1[d1] = 1; age1[d1] = 0; end
        else held1[d1] = 0;
      end
      if (KP2 && d2 >= 0) begin
        if (ps2_key[9]) begin held2[d2] = 1; made2[d2] = 1; age2[d2] = 0; end
        else held2[d2] = 0;
      end
    end
    if (bus.io_out && bus.io_n == 3'd2) m_latch = bus.io_dout[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input bit mk, input bit ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], mk, ext, code};
  endtask

  task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
    bus.io_out = 1'b1; bus.io_n = n; bus.io_dout = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.io_out = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2_key = 11'h400;
    bus.io_out = 1'b0; bus.io_n = 3'd0; bus.io_dout = 8'h00;
    tick(); tick();
    checks++; if (bus.key_latch !== 4'h0) begin failures++; $display("FAIL reset_latch actual=%h required=0", bus.key_latch); end
    checks++; if (bus.any_key !== 1'b0) begin failures++; $display("FAIL reset_any actual=%b required=0", bus.any_key); end
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus.ef3 !== 1'b0) begin failures++; $display("FAIL reset_ef3 actual=%b required=0", bus.ef3); end
    checks++; if (bus.ef4 !== 1'b0) begin failures++; $display("FAIL reset_ef4 actual=%b required=0", bus.ef4); end
    checks++; if (bus.any_key !== 1'b0) begin failures++; $display("FAIL release_any actual=%b required=0", bus.any_key); end
  endtask

  task automatic test_stretch();
    do_reset();
    cpu_out(3'd2, 8'h35); tick(); bus.io_out = 1'b0;
    send(1, 0, 8'h2E); tick();                 // make at edge N
    checks++; if (bus.key_latch !== 4'h5) begin failures++; $display("FAIL stretch_latch actual=%h required=5", bus.key_latch); end
    tick();                                    // edge N+1
    checks++; if (bus.ef3 !== 1'b1) begin failures++; $display("FAIL stretch_ef3_rise actual=%b required=1", bus.ef3); end
    send(0, 0, 8'h2E); tick();                 // break at edge N+2
    for (int k = 3; k <= 12; k++) begin
      tick();
      checks++;
      if (bus.ef3 !== (k <= HOLD)) begin
        failures++; $display("FAIL stretch_ef3_n%0d actual=%b required=%b", k, bus.ef3, (k <= HOLD));
      end
    end
  endtask

  task automatic test_latch_n();
    do_reset();
    send(1, 0, 8'h16); tick();
    cpu_out(3'd2, 8'h01); tick(); bus.io_out = 1'b0;
    tick();
    checks++; if (bus.ef3 !== 1'b1) begin failures++; $display("FAIL latch_ef3 actual=%b required=1", bus.ef3); end
    cpu_out(3'd3, 8'h02); tick(); bus.io_out = 1'b0;
    tick();
    checks++; if (bus.key_latch !== 4'h1) begin failures++; $display("FAIL latch_n3 actual=%h required=1", bus.key_latch); end
    checks++; if (bus.ef3 !== 1'b1) begin failures++; $display("FAIL latch_n3_ef3 actual=%b required=1", bus.ef3); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    send(1, 0, 8'h26); tick();
    send(1, 0, 8'h69); tick();
    send(1, 0, 8'h3E); tick();
    cpu_out(3'd2, 8'h0C); tick(); bus.io_out = 1'b0;
    tick(); tick();
    checks++; if (bus.key_latch !== 4'hC) begin failures++; $display("FAIL oor_latch actual=%h required=c", bus.key_latch); end
    checks++; if (bus.ef3 !== 1'b0) begin failures++; $display("FAIL oor_ef3 actual=%b required=0", bus.ef3); end
    checks++; if (bus.ef4 !== 1'b0) begin failures++; $display("FAIL oor_ef4 actual=%b required=0", bus.ef4); end
    checks++; if (bus.any_key !== 1'b1) begin failures++; $display("FAIL oor_any actual=%b required=1", bus.any_key); end
  endtask

  task automatic test_keypad2();
    do_reset();
    cpu_out(3'd2, 8'h02); tick(); bus.io_out = 1'b0;
    send(1, 1, 8'h72); tick(); tick();
    checks++; if (bus.ef4 !== 1'b0) begin failures++; $display("FAIL kp2_ext_ef4 actual=%b required=0", bus.ef4); end
    checks++; if (bus.any_key !== 1'b0) begin failures++; $display("FAIL kp2_ext_any actual=%b required=0", bus.any_key); end
    send(1, 0, 8'h72); tick(); tick();
    checks++; if (bus.ef4 !== KP2) begin failures++; $display("FAIL kp2_ef4 actual=%b required=%b", bus.ef4, KP2); end
    checks++; if (bus.ef3 !== 1'b0) begin failures++; $display("FAIL kp2_ef3 actual=%b required=0", bus.ef3); end
    checks++; if (bus.any_key !== KP2) begin failures++; $display("FAIL kp2_any actual=%b required=%b", bus.any_key, KP2); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cpu_out(3'd2, 8'h05); send(1, 0, 8'h2E); tick(); bus.io_out = 1'b0;
    checks++; if (bus.key_latch !== 4'h5) begin failures++; $display("FAIL simul_latch actual=%h required=5", bus.key_latch); end
    tick();
    checks++; if (bus.ef3 !== 1'b1) begin failures++; $display("FAIL simul_ef3 actual=%b required=1", bus.ef3); end
    send(0, 0, 8'h2E); tick(); tick();
    reset = 1'b1; tick();
    checks++; if (bus.ef3 !== 1'b0) begin failures++; $display("FAIL midreset_ef3 actual=%b required=0", bus.ef3); end
    checks++; if (dut.g_kp1[5].r_cnt !== 20'd0) begin failures++; $display("FAIL midreset_cnt actual=%0d required=0", dut.g_kp1[5].r_cnt); end
    reset = 1'b0; tick(); tick();
    checks++; if (bus.ef3 !== 1'b0) begin failures++; $display("FAIL postreset_ef3 actual=%b required=0", bus.ef3); end
  endtask

  task automatic test_random();
    int pick;
    logic [7:0] code;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) begin
        pick = $urandom_range(0, 20);
        if (pick < 10)      code = c_kp1[pick];
        else if (pick < 20) code = c_kp2[pick - 10];
        else                code = 8'($urandom);
        send(bit'($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), code);
      end
      bus.io_out  = ($urandom_range(0, 3) == 0);
      bus.io_n    = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom);
      bus.io_dout = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      tick();
      checks++; if (bus.ef3 !== exp_ef3) begin failures++; $display("FAIL rand_ef3 cyc=%0d actual=%b required=%b", c, bus.ef3, exp_ef3); end
      checks++; if (bus.ef4 !== exp_ef4) begin failures++; $display("FAIL rand_ef4 cyc=%0d actual=%b required=%b", c, bus.ef4, exp_ef4); end
      checks++; if (bus.any_key !== exp_any) begin failures++; $display("FAIL rand_any cyc=%0d actual=%b required=%b", c, bus.any_key, exp_any); end
      checks++; if (bus.key_latch !== m_latch) begin failures++; $display("FAIL rand_latch cyc=%0d actual=%h required=%h", c, bus.key_latch, m_latch); end
    end
    reset = 1'b0; bus.io_out = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_stretch();
    test_latch_n();
    test_out_of_range();
    test_keypad2();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
